l1_cache_core_param: RTL and testbench
======================================

Name: l1_cache_core_param

Overview:
- Parametrised successor to the per-core L1 cache model in the multicore cache simulator. One instance per core; CORE_ID is a parameter rather than a separate module per core.
- Provides a set-associative tag store with move-to-front LRU, MESI state per line, snoop handling and a prefetch-buffer hit check.
- New behaviours: single-cycle LRU reorder, dirty-victim writeback reporting, and a saturating hit counter.

Parameters:
- CORE_ID, 0, core number; informational only, carries no behaviour.
- WAY, 4, associativity; power of two, at least 2.
- BLOCK_SIZE_BYTE, 16, line size in bytes.
- CACHE_SIZE_BYTE, 32768, total capacity in bytes.
- ADDR_W, 32, address width.
- CNT_W, 20, width of the hit counter.
- Derived: OFF_W=log2(BLOCK_SIZE_BYTE), SET=CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY), IDX_W=log2(SET), TAG_W=ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- find_start  in  1  starts an access; sampled only in IDLE.
- ins_type  in  1  0=read, 1=write.
- tag  in  TAG_W  access tag.
- index  in  IDX_W  set index.
- block_offset  in  OFF_W  unused; kept for port compatibility.
- bus_signals  in  5  [4:3]==3 means own request; otherwise snoop, with [2:0] 100=BusRd, 010=BusRdX, 001=BusUpgr.
- other_copy  in  1  another core holds the line; sampled on a read miss.
- prefetch_hit  in  1  prefetch buffer hit; sampled in PREFETCH.
- found_in_cache  out  1  lookup result, valid from LOOKUP exit until IDLE.
- done_L1  out  1  one-cycle pulse when the lookup completes.
- updated  out  1  one-cycle pulse when the transaction completes.
- copy_out  out  1  snoop found a valid line; held until the next find_start.
- cache_hit_count  out  CNT_W  saturating count of hits.
- wb_valid  out  1  one-cycle pulse: dirty line written back.
- wb_tag  out  TAG_W  tag of the written-back line.
- wb_index  out  IDX_W  set index of the written-back line.

Behaviour:
- Line format: {valid, dirty, mesi[2:0], tag}. MESI encodings: I=000, E=001, S=010, M=011.
- Reset: all lines zero; state=IDLE; every output 0 (including done_L1). Reset mid-transaction aborts it; no updated pulse.
- States: IDLE, LOOKUP, PREFETCH, UPDATE.
- IDLE: on find_start, latch tag, index, ins_type and bus_signals. Clear copy_out. Go to LOOKUP.
- find_start in any other state is ignored.
- LOOKUP (1 cycle):
  - Compare all WAY ways in parallel; a hit requires valid=1 and a tag match.
  - Register found_in_cache and hit_way (lowest matching way). Pulse done_L1.
  - Own hit: hit_count+1. Next state UPDATE.
  - Own miss: next state PREFETCH.
  - Snoop: next state UPDATE; copy_out=1 if hit.
- PREFETCH (1 cycle): if prefetch_hit, hit_count+1. Next state UPDATE. Cache contents unchanged.
- UPDATE (1 cycle): performs one of the actions below, pulses updated, then returns to IDLE.
  - Own hit: rotate ways 0..hit_way so the hit line moves to way 0. If write, set dirty=1 and mesi=M.
  - Own miss: shift ways 0..WAY-2 down by one; the line in way WAY-1 is dropped. If the dropped line was valid and dirty, pulse wb_valid with its tag and index. Install at way 0:
    - read with other_copy=1: S, clean.
    - read with other_copy=0: E, clean.
    - write: M, dirty.
  - Snoop hit, BusRd: M becomes S with dirty cleared and a wb_valid pulse (flush); E becomes S.
  - Snoop hit, BusRdX on an M line: wb_valid pulse, then line zeroed.
  - Snoop hit, BusRdX on a non-M line, or BusUpgr: line zeroed.
  - Snoop miss: no change.
- Snoops never change LRU order.
- cache_hit_count saturates at 2^CNT_W-1 and does not wrap.
- Latency: own hit has done_L1 one cycle after find_start and updated two cycles after. A miss adds one cycle.

Optional Feature:
- Macro L1_STATS_EN.
- Defined: adds output ports miss_count (CNT_W) and wb_count (CNT_W), both saturating and cleared on reset.
  - miss_count increments on each own-request miss in LOOKUP, regardless of the prefetch result.
  - wb_count increments on each wb_valid pulse.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Read miss at index 5, tag 0x123, other_copy=0, prefetch_hit=0 -> done_L1 at +1, updated at +3, way0 holds {1,0,E,0x123}, hit_count=0.
- Write to the same address -> found_in_cache=1, updated at +2, way0 becomes M and dirty, hit_count=1.
- Fill set 5 with WAY+1 distinct writes -> on the last write, wb_valid pulses once with the first tag 0x123 and wb_index=5.
- Snoop BusRd (bus_signals=5'b00100) on an M line -> copy_out=1, wb_valid pulses, line becomes S and clean. Then BusRdX -> line valid=0.
- Four reads A,B,C,D to one set, then read A -> A moves to way0, order A,D,C,B; reset asserted during the following LOOKUP -> all outputs 0, state IDLE.
- Preload hit_count to max via repeated hits with CNT_W=4 -> count holds at 15.

Source files
------------

// File: rtl/l1_cache_core_param.sv
// Per-core set-associative L1 tag store: move-to-front LRU, MESI state, snoops, dirty writebacks.
// Optional miss/writeback counters are built when L1_STATS_EN is defined.
module l1_cache_core_param #(
  parameter int CORE_ID         = 0,
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  parameter int ADDR_W          = 32,
  parameter int CNT_W           = 20,
  localparam int OFF_W          = $clog2(BLOCK_SIZE_BYTE),
  localparam int SET            = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
  localparam int IDX_W          = $clog2(SET),
  localparam int TAG_W          = ADDR_W - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             find_start,
  input  logic             ins_type,
  input  logic [TAG_W-1:0] tag,
  input  logic [IDX_W-1:0] index,
  input  logic [OFF_W-1:0] block_offset,
  input  logic [4:0]       bus_signals,
  input  logic             other_copy,
  input  logic             prefetch_hit,
  output logic             found_in_cache,
  output logic             done_L1,
  output logic             updated,
  output logic             copy_out,
  output logic [CNT_W-1:0] cache_hit_count,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [IDX_W-1:0] wb_index
`ifdef L1_STATS_EN
  ,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  localparam int LINE_W = TAG_W + 5;
  localparam int WAY_W  = $clog2(WAY);
  localparam int V_BIT  = LINE_W - 1;
  localparam int D_BIT  = LINE_W - 2;
  localparam int M_LO   = TAG_W;
  localparam int M_HI   = TAG_W + 2;

  localparam logic [2:0] MESI_E = 3'b001;
  localparam logic [2:0] MESI_S = 3'b010;
  localparam logic [2:0] MESI_M = 3'b011;

  typedef logic [LINE_W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, LOOKUP, PREFETCH, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [4:0]         bus_q, bus_d;
  logic               found_q, found_d;
  logic [WAY_W-1:0]   hit_way_q, hit_way_d;
  logic               copy_q, copy_d;
  logic               done_q, done_d;
  logic               upd_q, upd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic [IDX_W-1:0]   wb_index_q, wb_index_d;
  logic               hit_inc;
  logic               miss_inc;

  // Way 0 of each set is the most recently used line.
  line_t              lines_q [SET][WAY];
  line_t              row     [WAY];
  line_t              row_new [WAY];
  logic [WAY-1:0]     hit_vec;
  logic [WAY_W-1:0]   hit_idx;
  logic               hit_any;
  logic               own_req;
  logic               upd_wb;
  logic [TAG_W-1:0]   upd_wb_tag;
  line_t              hl;
  line_t              sl;
  logic               unused_ok;

  assign unused_ok = ^{block_offset, CORE_ID[0]};
  assign own_req   = (bus_q[4:3] == 2'b11);
  assign hit_any   = |hit_vec;

  for (genvar gi = 0; gi < WAY; gi++) begin : g_way
    assign row[gi]     = lines_q[idx_q][gi];
    assign hit_vec[gi] = row[gi][V_BIT] && (row[gi][TAG_W-1:0] == tag_q);
  end

  always_comb begin
    hit_idx = '0;
    for (int w = WAY - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_idx = w[WAY_W-1:0];
    end
  end

  // Next contents of the addressed set; committed only in UPDATE.
  always_comb begin
    for (int w = 0; w < WAY; w++) row_new[w] = row[w];
    upd_wb     = 1'b0;
    upd_wb_tag = '0;
    hl         = row[hit_way_q];
    sl         = row[hit_way_q];
    if (own_req) begin
      if (found_q) begin
        if (wr_q) begin
          hl[D_BIT]     = 1'b1;
          hl[M_HI:M_LO] = MESI_M;
        end
        for (int w = 1; w < WAY; w++) begin
          if (w <= int'(hit_way_q)) row_new[w] = row[w-1];
        end
        row_new[0] = hl;
      end else begin
        for (int w = 1; w < WAY; w++) row_new[w] = row[w-1];
        row_new[0] = {1'b1, wr_q, wr_q ? MESI_M : (other_copy ? MESI_S : MESI_E), tag_q};
        if (row[WAY-1][V_BIT] && row[WAY-1][D_BIT]) begin
          upd_wb     = 1'b1;
          upd_wb_tag = row[WAY-1][TAG_W-1:0];
        end
      end
    end else if (found_q) begin
      case (bus_q[2:0])
        3'b100: begin
          if (sl[M_HI:M_LO] == MESI_M) begin
            upd_wb        = 1'b1;
            upd_wb_tag    = sl[TAG_W-1:0];
            sl[D_BIT]     = 1'b0;
            sl[M_HI:M_LO] = MESI_S;
          end else if (sl[M_HI:M_LO] == MESI_E) begin
            sl[M_HI:M_LO] = MESI_S;
          end
        end
        3'b010: begin
          if (sl[M_HI:M_LO] == MESI_M) begin
            upd_wb     = 1'b1;
            upd_wb_tag = sl[TAG_W-1:0];
          end
          sl = '0;
        end
        3'b001:  sl = '0;
        default: ;
      endcase
      row_new[hit_way_q] = sl;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    bus_d      = bus_q;
    found_d    = found_q;
    hit_way_d  = hit_way_q;
    copy_d     = copy_q;
    done_d     = 1'b0;
    upd_d      = 1'b0;
    wb_valid_d = 1'b0;
    wb_tag_d   = wb_tag_q;
    wb_index_d = wb_index_q;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (find_start) begin
          tag_d   = tag;
          idx_d   = index;
          wr_d    = ins_type;
          bus_d   = bus_signals;
          copy_d  = 1'b0;
          found_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        found_d   = hit_any;
        hit_way_d = hit_idx;
        done_d    = 1'b1;
        if (own_req) begin
          hit_inc  = hit_any;
          miss_inc = !hit_any;
          state_d  = hit_any ? UPDATE : PREFETCH;
        end else begin
          if (hit_any) copy_d = 1'b1;
          state_d = UPDATE;
        end
      end
      PREFETCH: begin
        hit_inc = prefetch_hit;
        state_d = UPDATE;
      end
      UPDATE: begin
        upd_d = 1'b1;
        if (upd_wb) begin
          wb_valid_d = 1'b1;
          wb_tag_d   = upd_wb_tag;
          wb_index_d = idx_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (hit_inc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      bus_q      <= '0;
      found_q    <= 1'b0;
      hit_way_q  <= '0;
      copy_q     <= 1'b0;
      done_q     <= 1'b0;
      upd_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_index_q <= '0;
      for (int s = 0; s < SET; s++) begin
        for (int w = 0; w < WAY; w++) lines_q[s][w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      bus_q      <= bus_d;
      found_q    <= found_d;
      hit_way_q  <= hit_way_d;
      copy_q     <= copy_d;
      done_q     <= done_d;
      upd_q      <= upd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_index_q <= wb_index_d;
      if (state_q == UPDATE) begin
        for (int w = 0; w < WAY; w++) lines_q[idx_q][w] <= row_new[w];
      end
    end
  end

`ifdef L1_STATS_EN
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    miss_cnt_d = (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    wb_cnt_d   = (wb_valid_d && (wb_cnt_q != {CNT_W{1'b1}})) ? wb_cnt_q + 1'b1 : wb_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  logic unused_miss;
  assign unused_miss = miss_inc;
`endif

  assign found_in_cache  = found_q;
  assign done_L1         = done_q;
  assign updated         = upd_q;
  assign copy_out        = copy_q;
  assign cache_hit_count = cnt_q;
  assign wb_valid        = wb_valid_q;
  assign wb_tag          = wb_tag_q;
  assign wb_index        = wb_index_q;

endmodule

// File: tb/tb_l1_cache_core_param.sv
// Self-checking bench for l1_cache_core_param: directed scenarios plus random traffic
// checked against a queue-based MRU-ordered cache model.
module tb_l1_cache_core_param;
  localparam int WAY    = 4;
  localparam int BLK    = 16;
  localparam int CSIZE  = 1024;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int OFF_W  = $clog2(BLK);
  localparam int SET    = CSIZE / (BLK * WAY);
  localparam int IDX_W  = $clog2(SET);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int HMAX   = (1 << CNT_W) - 1;
  localparam logic [4:0] OWN = 5'b11000;
  localparam logic [2:0] ST_E = 3'b001, ST_S = 3'b010, ST_M = 3'b011;

  typedef struct packed {
    logic v;
    logic d;
    logic [2:0] m;
    logic [TAG_W-1:0] t;
  } mline_t;

  logic clk = 1'b0;
  logic reset, find_start, ins_type, other_copy, prefetch_hit;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [OFF_W-1:0] block_offset;
  logic [4:0] bus_signals;
  logic found_in_cache, done_L1, updated, copy_out, wb_valid;
  logic [CNT_W-1:0] cache_hit_count;
  logic [TAG_W-1:0] wb_tag;
  logic [IDX_W-1:0] wb_index;
`ifdef L1_STATS_EN
  logic [CNT_W-1:0] miss_count, wb_count;
`endif

  l1_cache_core_param #(
    .CORE_ID(1), .WAY(WAY), .BLOCK_SIZE_BYTE(BLK), .CACHE_SIZE_BYTE(CSIZE),
    .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .find_start(find_start), .ins_type(ins_type),
    .tag(tag), .index(index), .block_offset(block_offset), .bus_signals(bus_signals),
    .other_copy(other_copy), .prefetch_hit(prefetch_hit),
    .found_in_cache(found_in_cache), .done_L1(done_L1), .updated(updated),
    .copy_out(copy_out), .cache_hit_count(cache_hit_count), .wb_valid(wb_valid),
    .wb_tag(wb_tag), .wb_index(wb_index)
`ifdef L1_STATS_EN
    , .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Reference model: each set is a queue ordered most- to least-recently used.
  mline_t mq [SET][$];
  int m_hits, m_miss, m_wb;
  logic e_found, e_copy;
  int e_upd, e_wbn;
  logic [TAG_W-1:0] e_wbtag;

  int o_done_n, o_done_cyc, o_upd_n, o_upd_cyc, o_wb_n, o_hits;
  logic o_found, o_copy;
  logic [TAG_W-1:0] o_wb_tag;
  logic [IDX_W-1:0] o_wb_idx;

  function automatic int sat(input int v);
    return (v < HMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SET; s++) begin
      mq[s].delete();
      for (int w = 0; w < WAY; w++) mq[s].push_back('0);
    end
    m_hits = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  task automatic model_apply(input logic [4:0] bus, input logic wr, input logic [TAG_W-1:0] t,
                             input logic [IDX_W-1:0] s, input logic oc, input logic pf);
    int p;
    mline_t ln, vic;
    p = -1;
    for (int i = 0; i < WAY; i++)
      if (p < 0 && mq[s][i].v && mq[s][i].t == t) p = i;
    e_found = (p >= 0);
    e_copy  = 1'b0;
    e_wbn   = 0;
    e_wbtag = '0;
    e_upd   = 2;
    if (bus[4:3] == 2'b11) begin
      if (p >= 0) begin
        ln = mq[s][p];
        mq[s].delete(p);
        if (wr) begin ln.d = 1'b1; ln.m = ST_M; end
        mq[s].push_front(ln);
        m_hits = sat(m_hits);
      end else begin
        e_upd = 3;
        m_miss = sat(m_miss);
        if (pf) m_hits = sat(m_hits);
        vic = mq[s].pop_back();
        if (vic.v && vic.d) begin e_wbn = 1; e_wbtag = vic.t; end
        ln = {1'b1, wr, wr ? ST_M : (oc ? ST_S : ST_E), t};
        mq[s].push_front(ln);
      end
    end else if (p >= 0) begin
      e_copy = 1'b1;
      ln = mq[s][p];
      if (bus[2:0] == 3'b100) begin
        if (ln.m == ST_M) begin e_wbn = 1; e_wbtag = ln.t; ln.m = ST_S; ln.d = 1'b0; end
        else if (ln.m == ST_E) ln.m = ST_S;
      end else if (bus[2:0] == 3'b010) begin
        if (ln.m == ST_M) begin e_wbn = 1; e_wbtag = ln.t; end
        ln = '0;
      end else if (bus[2:0] == 3'b001) begin
        ln = '0;
      end
      mq[s][p] = ln;
    end
    if (e_wbn == 1) m_wb = sat(m_wb);
  endtask

  // Drives one transaction from a negedge and records what the DUT does in the next 4 cycles.
  task automatic run_txn(input logic [4:0] bus, input logic wr, input logic [TAG_W-1:0] t,
                         input logic [IDX_W-1:0] s, input logic oc, input logic pf);
    o_done_n = 0; o_done_cyc = 0; o_upd_n = 0; o_upd_cyc = 0; o_wb_n = 0;
    o_found = 1'b0; o_wb_tag = '0; o_wb_idx = '0;
    ins_type = wr; tag = t; index = s; bus_signals = bus; other_copy = oc; prefetch_hit = pf;
    block_offset = OFF_W'($urandom);
    find_start = 1'b1;
    @(posedge clk);
    #1 find_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_L1) begin o_done_n++; o_done_cyc = c; o_found = found_in_cache; end
      if (updated) begin o_upd_n++; o_upd_cyc = c; end
      if (wb_valid) begin o_wb_n++; o_wb_tag = wb_tag; o_wb_idx = wb_index; end
    end
    o_copy = copy_out;
    o_hits = int'(cache_hit_count);
    txn_no++;
    $display("txn %0d bus=%b wr=%0d idx=%0d tag=%h found=%0d upd@%0d wb=%0d/%h copy=%0d hits=%0d",
             txn_no, bus, wr, s, t, o_found, o_upd_cyc, o_wb_n, o_wb_tag, o_copy, o_hits);
  endtask

  task automatic txn(input logic [4:0] bus, input logic wr, input logic [TAG_W-1:0] t,
                     input logic [IDX_W-1:0] s, input logic oc, input logic pf);
    model_apply(bus, wr, t, s, oc, pf);
    run_txn(bus, wr, t, s, oc, pf);
  endtask

  task automatic test_reset();
    reset = 1'b1; find_start = 1'b0; ins_type = 1'b0; tag = '0; index = '0;
    block_offset = '0; bus_signals = '0; other_copy = 1'b0; prefetch_hit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if ({done_L1, updated, found_in_cache, copy_out, wb_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {done_L1, updated, found_in_cache, copy_out, wb_valid});
    end
    checks++;
    if (cache_hit_count !== '0) begin errors++; $display("FAIL reset_hits: got %0d expected 0", cache_hit_count); end
    checks++;
    if ({wb_tag, wb_index} !== '0) begin errors++; $display("FAIL reset_wb: got %h/%0d expected 0/0", wb_tag, wb_index); end
  endtask

  task automatic test_read_miss();
    txn(OWN, 1'b0, 24'h123, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_done_n !== 1 || o_done_cyc !== 1) begin errors++; $display("FAIL rmiss_done: got n=%0d cyc=%0d expected n=1 cyc=1", o_done_n, o_done_cyc); end
    checks++;
    if (o_upd_n !== 1 || o_upd_cyc !== 3) begin errors++; $display("FAIL rmiss_updated: got n=%0d cyc=%0d expected n=1 cyc=3", o_upd_n, o_upd_cyc); end
    checks++;
    if (o_found !== 1'b0) begin errors++; $display("FAIL rmiss_found: got %0d expected 0", o_found); end
    checks++;
    if (o_hits !== 0 || o_wb_n !== 0) begin errors++; $display("FAIL rmiss_hits_wb: got hits=%0d wb=%0d expected 0/0", o_hits, o_wb_n); end
  endtask

  task automatic test_write_hit();
    txn(OWN, 1'b1, 24'h123, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_found !== 1'b1) begin errors++; $display("FAIL whit_found: got %0d expected 1", o_found); end
    checks++;
    if (o_upd_n !== 1 || o_upd_cyc !== 2) begin errors++; $display("FAIL whit_updated: got n=%0d cyc=%0d expected n=1 cyc=2", o_upd_n, o_upd_cyc); end
    checks++;
    if (o_hits !== 1) begin errors++; $display("FAIL whit_hits: got %0d expected 1", o_hits); end
  endtask

  task automatic test_fill_evict();
    logic [TAG_W-1:0] tags [5];
    tags[0] = 24'h123; tags[1] = 24'h200; tags[2] = 24'h201; tags[3] = 24'h202; tags[4] = 24'h203;
    for (int i = 0; i < WAY + 1; i++) begin
      txn(OWN, 1'b1, tags[i], 4'd5, 1'b0, 1'b0);
      checks++;
      if (o_wb_n !== ((i == WAY) ? 1 : 0)) begin errors++; $display("FAIL fill_wb_count[%0d]: got %0d expected %0d", i, o_wb_n, (i == WAY) ? 1 : 0); end
    end
    checks++;
    if (o_wb_tag !== 24'h123 || o_wb_idx !== 4'd5) begin errors++; $display("FAIL fill_wb_addr: got %h/%0d expected 123/5", o_wb_tag, o_wb_idx); end
  endtask

  task automatic test_snoop();
    txn(5'b00100, 1'b0, 24'h202, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_copy !== 1'b1 || o_wb_n !== 1 || o_wb_tag !== 24'h202) begin
      errors++; $display("FAIL snoop_busrd_m: got copy=%0d wb=%0d tag=%h expected 1/1/202", o_copy, o_wb_n, o_wb_tag);
    end
    checks++;
    if (o_upd_cyc !== 2 || o_hits !== m_hits) begin errors++; $display("FAIL snoop_timing_hits: got cyc=%0d hits=%0d expected 2/%0d", o_upd_cyc, o_hits, m_hits); end
    txn(5'b01100, 1'b0, 24'h202, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_copy !== 1'b1 || o_wb_n !== 0) begin errors++; $display("FAIL snoop_shared_clean: got copy=%0d wb=%0d expected 1/0", o_copy, o_wb_n); end
    txn(5'b00010, 1'b0, 24'h202, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_copy !== 1'b1 || o_wb_n !== 0) begin errors++; $display("FAIL snoop_busrdx_s: got copy=%0d wb=%0d expected 1/0", o_copy, o_wb_n); end
    txn(5'b00100, 1'b0, 24'h202, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_copy !== 1'b0) begin errors++; $display("FAIL snoop_invalidated: got copy=%0d expected 0", o_copy); end
    txn(OWN, 1'b1, 24'h300, 4'd5, 1'b0, 1'b0);
    checks++;
    if (o_wb_n !== 1 || o_wb_tag !== 24'h200) begin errors++; $display("FAIL snoop_lru_kept: got wb=%0d tag=%h expected 1/200", o_wb_n, o_wb_tag); end
  endtask

  task automatic test_lru_and_reset_mid();
    int upd_seen;
    txn(OWN, 1'b1, 24'hA, 4'd9, 1'b0, 1'b0);
    txn(OWN, 1'b1, 24'hB, 4'd9, 1'b0, 1'b0);
    txn(OWN, 1'b1, 24'hC, 4'd9, 1'b0, 1'b0);
    txn(OWN, 1'b1, 24'hD, 4'd9, 1'b0, 1'b0);
    txn(OWN, 1'b0, 24'hA, 4'd9, 1'b0, 1'b0);
    checks++;
    if (o_found !== 1'b1) begin errors++; $display("FAIL lru_read_a: got found=%0d expected 1", o_found); end
    txn(OWN, 1'b1, 24'hE, 4'd9, 1'b0, 1'b0);
    checks++;
    if (o_wb_n !== 1 || o_wb_tag !== 24'hB || o_wb_idx !== 4'd9) begin
      errors++; $display("FAIL lru_victim: got wb=%0d tag=%h idx=%0d expected 1/b/9", o_wb_n, o_wb_tag, o_wb_idx);
    end
    ins_type = 1'b0; tag = 24'hA; index = 4'd9; bus_signals = OWN; find_start = 1'b1;
    @(posedge clk);
    #1 find_start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done_L1, updated, found_in_cache, copy_out, wb_valid} !== 5'b0 || cache_hit_count !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got flags=%b hits=%0d expected 00000/0",
                         {done_L1, updated, found_in_cache, copy_out, wb_valid}, cache_hit_count);
    end
    reset = 1'b0;
    model_reset();
    upd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (updated || done_L1) upd_seen++;
    end
    checks++;
    if (upd_seen !== 0) begin errors++; $display("FAIL reset_mid_abort: got %0d pulses expected 0", upd_seen); end
    txn(OWN, 1'b0, 24'hA, 4'd9, 1'b0, 1'b0);
    checks++;
    if (o_found !== 1'b0) begin errors++; $display("FAIL reset_mid_cleared: got found=%0d expected 0", o_found); end
  endtask

  task automatic test_random();
    logic [4:0] bus;
    logic [2:0] ops [3];
    logic [IDX_W-1:0] s;
    logic [TAG_W-1:0] t;
    logic wr, oc, pf;
    ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b001;
    for (int n = 0; n < 250; n++) begin
      s  = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'd7;
      t  = 24'h400 + TAG_W'($urandom_range(0, 5));
      wr = 1'($urandom); oc = 1'($urandom); pf = 1'($urandom);
      if ($urandom_range(0, 9) < 7) bus = OWN;
      else bus = {2'($urandom_range(0, 2)), ops[$urandom_range(0, 2)]};
      txn(bus, wr, t, s, oc, pf);
      checks++;
      if (o_done_n !== 1 || o_done_cyc !== 1) begin errors++; $display("FAIL rnd_done[%0d]: got n=%0d cyc=%0d expected 1/1", n, o_done_n, o_done_cyc); end
      checks++;
      if (o_upd_n !== 1 || o_upd_cyc !== e_upd) begin errors++; $display("FAIL rnd_updated[%0d]: got n=%0d cyc=%0d expected 1/%0d", n, o_upd_n, o_upd_cyc, e_upd); end
      checks++;
      if (o_found !== e_found) begin errors++; $display("FAIL rnd_found[%0d]: got %0d expected %0d", n, o_found, e_found); end
      checks++;
      if (o_wb_n !== e_wbn || (e_wbn == 1 && (o_wb_tag !== e_wbtag || o_wb_idx !== s))) begin
        errors++; $display("FAIL rnd_wb[%0d]: got n=%0d %h/%0d expected n=%0d %h/%0d", n, o_wb_n, o_wb_tag, o_wb_idx, e_wbn, e_wbtag, s);
      end
      checks++;
      if (o_copy !== e_copy) begin errors++; $display("FAIL rnd_copy[%0d]: got %0d expected %0d", n, o_copy, e_copy); end
      checks++;
      if (o_hits !== m_hits) begin errors++; $display("FAIL rnd_hits[%0d]: got %0d expected %0d", n, o_hits, m_hits); end
    end
`ifdef L1_STATS_EN
    checks++;
    if (int'(miss_count) !== m_miss || int'(wb_count) !== m_wb) begin
      errors++; $display("FAIL stats: got miss=%0d wb=%0d expected %0d/%0d", miss_count, wb_count, m_miss, m_wb);
    end
`endif
  endtask

  task automatic test_hit_saturation();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
    txn(OWN, 1'b0, 24'h777, 4'd2, 1'b0, 1'b0);
    for (int n = 0; n < 18; n++) begin
      txn(OWN, 1'b0, 24'h777, 4'd2, 1'b0, 1'b0);
      checks++;
      if (o_hits !== m_hits) begin errors++; $display("FAIL sat_hits[%0d]: got %0d expected %0d", n, o_hits, m_hits); end
    end
    checks++;
    if (cache_hit_count !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", cache_hit_count); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_fill_evict();
    test_snoop();
    test_lru_and_reset_mid();
    test_random();
    test_hit_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
